// File: rtl/set_assoc_wb_cache.sv
// N-way set-associative write-back cache: combinational IDLE lookup, dirty-victim
// write-back, line fill with store merge, snoop invalidate on any cycle.
module set_assoc_wb_cache #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int OFFSET_LENGTH = 4,
  parameter int INDEX_LENGTH  = 6,
  parameter int WAYS          = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    avalid,
  input  logic [ADDR_WIDTH-1:0]                   aaddr,
  input  logic                                    load,
  input  logic [DATA_WIDTH-1:0]                   data_from_cpu,
  output logic [DATA_WIDTH-1:0]                   data_to_cpu,
  output logic                                    hit,
  output logic                                    command_valid,
  output logic                                    command_store,
  output logic                                    command_rready,
  output logic [ADDR_WIDTH-1:0]                   command_addr,
  output logic [(DATA_WIDTH<<OFFSET_LENGTH)-1:0]  data_to_bus,
  input  logic [(DATA_WIDTH<<OFFSET_LENGTH)-1:0]  data_from_bus,
  input  logic                                    bus_valid,
  input  logic                                    bus_ready,
  input  logic                                    invalidate,
  input  logic [ADDR_WIDTH-1:0]                   invalidate_addr
);
  localparam int TAG_LENGTH = ADDR_WIDTH - INDEX_LENGTH - OFFSET_LENGTH;
  localparam int LINE_W     = DATA_WIDTH << OFFSET_LENGTH;
  localparam int SETS       = 1 << INDEX_LENGTH;
  localparam int WAY_W      = $clog2(WAYS);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FILL      = 2'd2;

  logic [1:0]              state;
  logic [WAYS-1:0]         valid_q [SETS];
  logic [WAYS-1:0]         dirty_q [SETS];
  logic [WAY_W-1:0]        rr_ptr  [SETS];
  logic [TAG_LENGTH-1:0]   tags    [SETS][WAYS];
  logic [LINE_W-1:0]       data    [SETS][WAYS];

  logic [WAY_W-1:0]        vic_way;
  logic                    vic_rr;
  logic [TAG_LENGTH-1:0]   vic_tag;
  logic [LINE_W-1:0]       vic_line;
  logic [TAG_LENGTH-1:0]   req_tag;
  logic [INDEX_LENGTH-1:0] req_idx;

  logic [OFFSET_LENGTH-1:0] off;
  logic [INDEX_LENGTH-1:0]  idx, inv_idx;
  logic [TAG_LENGTH-1:0]    tag, inv_tag;
  assign off     = aaddr[OFFSET_LENGTH-1:0];
  assign idx     = aaddr[OFFSET_LENGTH +: INDEX_LENGTH];
  assign tag     = aaddr[ADDR_WIDTH-1 -: TAG_LENGTH];
  assign inv_idx = invalidate_addr[OFFSET_LENGTH +: INDEX_LENGTH];
  assign inv_tag = invalidate_addr[ADDR_WIDTH-1 -: TAG_LENGTH];

  logic unused_inv_offset;
  assign unused_inv_offset = ^invalidate_addr[OFFSET_LENGTH-1:0];

  // Per-way tag compare for the CPU lookup and for the snoop port.
  logic [WAYS-1:0] way_hit, inv_hit;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_hit[w] = valid_q[idx][w] && (tags[idx][w] == tag);
    assign inv_hit[w] = invalidate && valid_q[inv_idx][w] && (tags[inv_idx][w] == inv_tag);
  end

  logic [WAY_W-1:0] hit_way;
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_way = WAY_W'(w);
  end

  // Lowest invalid way wins; only a full set falls back to the round-robin pointer.
  logic [WAY_W-1:0] vic_sel;
  logic             sel_rr;
  always_comb begin
    vic_sel = rr_ptr[idx];
    sel_rr  = 1'b1;
    for (int w = WAYS-1; w >= 0; w--)
      if (!valid_q[idx][w]) begin
        vic_sel = WAY_W'(w);
        sel_rr  = 1'b0;
      end
  end

  logic [LINE_W-1:0] hit_line;
  assign hit_line    = data[idx][hit_way];
  assign hit         = (state == IDLE) && avalid && (|way_hit) && !invalidate;
  assign data_to_cpu = hit ? hit_line[off*DATA_WIDTH +: DATA_WIDTH] : '0;

  logic store_fire, fill_fire;
  assign store_fire = hit && !load;
  assign fill_fire  = (state == FILL) && bus_valid && !invalidate;

  logic [LINE_W-1:0] fill_line;
  always_comb begin
    fill_line = data_from_bus;
    if (!load) fill_line[off*DATA_WIDTH +: DATA_WIDTH] = data_from_cpu;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      vic_way  <= '0;
      vic_rr   <= 1'b0;
      vic_tag  <= '0;
      vic_line <= '0;
      req_tag  <= '0;
      req_idx  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_ptr[s]  <= '0;
      end
    end else begin
      if (!invalidate) begin
        case (state)
          IDLE: if (avalid) begin
            if (|way_hit) begin
              if (!load) dirty_q[idx][hit_way] <= 1'b1;
            end else begin
              vic_way  <= vic_sel;
              vic_rr   <= sel_rr;
              vic_tag  <= tags[idx][vic_sel];
              vic_line <= data[idx][vic_sel];
              req_tag  <= tag;
              req_idx  <= idx;
              state    <= (valid_q[idx][vic_sel] && dirty_q[idx][vic_sel]) ? WRITEBACK : FILL;
            end
          end
          WRITEBACK: if (bus_ready) begin
            dirty_q[req_idx][vic_way] <= 1'b0;
            state <= FILL;
          end
          FILL: if (bus_valid) begin
            valid_q[req_idx][vic_way] <= 1'b1;
            dirty_q[req_idx][vic_way] <= !load;
            if (vic_rr) rr_ptr[req_idx] <= rr_ptr[req_idx] + WAY_W'(1);
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      for (int w = 0; w < WAYS; w++)
        if (inv_hit[w]) begin
          valid_q[inv_idx][w] <= 1'b0;
          dirty_q[inv_idx][w] <= 1'b0;
        end
    end
  end

  // Tag/data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (store_fire) data[idx][hit_way][off*DATA_WIDTH +: DATA_WIDTH] <= data_from_cpu;
    if (fill_fire) begin
      data[req_idx][vic_way] <= fill_line;
      tags[req_idx][vic_way] <= req_tag;
    end
  end

  assign command_valid  = (state == WRITEBACK) || (state == FILL);
  assign command_store  = (state == WRITEBACK);
  assign command_rready = (state == FILL);
  assign data_to_bus    = (state == WRITEBACK) ? vic_line : '0;
  always_comb begin
    command_addr = '0;
    if (state == WRITEBACK) command_addr = {vic_tag, req_idx, {OFFSET_LENGTH{1'b0}}};
    else if (state == FILL) command_addr = {req_tag, req_idx, {OFFSET_LENGTH{1'b0}}};
  end
endmodule
